// File: rtl/instruction_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instruction_encoder_pkg
// Shared RV32I encoding definitions: base opcodes, instruction formats and
// the immediate ranges each format can carry. Used by the instruction
// encoder, its packer and the immediate decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package instruction_encoder_pkg;

    // RV32I base opcodes (bits [6:0] of every instruction).
    typedef enum logic [6:0] {
        OP_LOAD      = 7'b0000011,
        OP_IMM_ARITH = 7'b0010011,
        OP_AUIPC     = 7'b0010111,
        OP_STORE     = 7'b0100011,
        OP_REG       = 7'b0110011,
        OP_LUI       = 7'b0110111,
        OP_BRANCH    = 7'b1100011,
        OP_JALR      = 7'b1100111,
        OP_JAL       = 7'b1101111
    } opcode_t;

    // Instruction formats; decides how fields are packed.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_t;

    // Signed immediate ranges representable by each format. B and J
    // immediates are byte offsets that must also be even.
    localparam int signed IMM_I_MIN = -32'sd2048;
    localparam int signed IMM_I_MAX = 32'sd2047;
    localparam int signed IMM_S_MIN = -32'sd2048;
    localparam int signed IMM_S_MAX = 32'sd2047;
    localparam int signed IMM_B_MIN = -32'sd4096;
    localparam int signed IMM_B_MAX = 32'sd4094;
    localparam int signed IMM_J_MIN = -32'sd1048576;
    localparam int signed IMM_J_MAX = 32'sd1048574;

    // Map an opcode to its instruction format; unknown opcodes are R-type.
    function automatic format_t opcode_format(input opcode_t op);
        format_t fmt;
        case (op)
            OP_LOAD, OP_IMM_ARITH, OP_JALR: fmt = FMT_I;
            OP_STORE:                       fmt = FMT_S;
            OP_BRANCH:                      fmt = FMT_B;
            OP_AUIPC, OP_LUI:               fmt = FMT_U;
            OP_JAL:                         fmt = FMT_J;
            default:                        fmt = FMT_R;
        endcase
        return fmt;
    endfunction

    // True when a 32-bit two's-complement immediate lies within [lo, hi].
    function automatic logic imm_in_range(input logic [31:0] imm,
                                          input int signed lo,
                                          input int signed hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// ---------------------------------------------------------------------------
// instruction_packer
// Purely combinational: selects the format from the opcode, packs the
// fields into a 32-bit RV32I word and checks that the immediate fits.
// Ports:
//   opcode, rd, rs1, rs2, funct3, funct7, immediate : instruction fields
//   instruction  : packed 32-bit word (meaningful only when immediate_ok)
//   immediate_ok : immediate is representable in the selected format
// ---------------------------------------------------------------------------
module instruction_packer
    import instruction_encoder_pkg::*;
(
    input  opcode_t     opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] immediate,
    output logic [31:0] instruction,
    output logic        immediate_ok
);

    format_t format_s;

    // Format selection, field packing and immediate range check.
    always_comb begin
        format_s     = opcode_format(opcode);
        instruction  = 32'h0000_0000;
        immediate_ok = 1'b1;
        case (format_s)
            FMT_I: begin
                instruction  = {immediate[11:0], rs1, funct3, rd, opcode};
                immediate_ok = imm_in_range(immediate, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_S: begin
                instruction  = {immediate[11:5], rs2, rs1, funct3,
                                immediate[4:0], opcode};
                immediate_ok = imm_in_range(immediate, IMM_S_MIN, IMM_S_MAX);
            end
            FMT_B: begin
                instruction  = {immediate[12], immediate[10:5], rs2, rs1,
                                funct3, immediate[4:1], immediate[11], opcode};
                immediate_ok = imm_in_range(immediate, IMM_B_MIN, IMM_B_MAX)
                               && (immediate[0] == 1'b0);
            end
            FMT_U: begin
                // U immediates carry only the upper 20 bits; any low bit set
                // would be silently lost, so it is an error.
                instruction  = {immediate[31:12], rd, opcode};
                immediate_ok = (immediate[11:0] == 12'h000);
            end
            FMT_J: begin
                instruction  = {immediate[20], immediate[10:1], immediate[11],
                                immediate[19:12], rd, opcode};
                immediate_ok = imm_in_range(immediate, IMM_J_MIN, IMM_J_MAX)
                               && (immediate[0] == 1'b0);
            end
            default: begin
                // R-type: immediate is not encoded, so it can never be wrong.
                instruction  = {funct7, rs2, rs1, funct3, rd, opcode};
                immediate_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
// Accepts instruction fields over a valid/ready handshake, packs them into
// RV32I words, tags each word with a running byte address and buffers the
// result in a 2-entry FIFO. Inputs whose immediate does not fit are dropped
// and counted.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is registered)
//   in_opcode .. in_immediate : instruction fields
//   out_valid / out_ready : output handshake; out_instruction/out_address
//                           present the FIFO head
//   address_load(_value)  : override address of the next emitted instruction
//   error, error_count    : sticky range error, saturating reject count
//   error_clear           : clears error and error_count
// ---------------------------------------------------------------------------
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  opcode_t                  in_opcode,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [31:0]              in_immediate,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    input  logic                     address_load,
    input  logic [ADDRESS_WIDTH-1:0] address_load_value,
    output logic                     error,
    output logic [7:0]               error_count,
    input  logic                     error_clear
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(3'd4);

    // FIFO kept as a shift pair: entry 0 is always the head, so the output
    // ports come straight from registers and stay stable under backpressure.
    logic                     valid0_r;
    logic                     valid1_r;
    logic [31:0]              instr0_r;
    logic [31:0]              instr1_r;
    logic [ADDRESS_WIDTH-1:0] addr0_r;
    logic [ADDRESS_WIDTH-1:0] addr1_r;

    logic [ADDRESS_WIDTH-1:0] address_r;
    logic [ADDRESS_WIDTH-1:0] address_next_s;
    logic [ADDRESS_WIDTH-1:0] tag_s;
    logic                     error_r;
    logic                     error_next_s;
    logic [7:0]               error_count_r;
    logic [7:0]               error_count_next_s;

    logic [31:0] packed_s;
    logic        immediate_ok_s;
    logic        accept_s;
    logic        push_s;
    logic        reject_s;
    logic        pop_s;

    instruction_packer u_packer (
        .opcode       (in_opcode),
        .rd           (in_rd),
        .rs1          (in_rs1),
        .rs2          (in_rs2),
        .funct3       (in_funct3),
        .funct7       (in_funct7),
        .immediate    (in_immediate),
        .instruction  (packed_s),
        .immediate_ok (immediate_ok_s)
    );

    // in_ready depends only on FIFO state, so there is no path from
    // in_valid or out_ready; a full FIFO refuses even when it is popped.
    assign in_ready        = ~valid1_r;
    assign out_valid       = valid0_r;
    assign out_instruction = instr0_r;
    assign out_address     = addr0_r;
    assign error           = error_r;
    assign error_count     = error_count_r;

    assign accept_s = in_valid & ~valid1_r;
    assign push_s   = accept_s & immediate_ok_s;
    assign reject_s = accept_s & ~immediate_ok_s;
    assign pop_s    = valid0_r & out_ready;

    // Address tagging: a load overrides the tag for this cycle's instruction.
    always_comb begin
        tag_s = address_r;
        if (address_load) begin
            tag_s = address_load_value;
        end else begin
            tag_s = address_r;
        end
        // Advance only when an instruction is actually emitted.
        address_next_s = tag_s;
        if (push_s) begin
            address_next_s = tag_s + ADDR_STEP;
        end else begin
            address_next_s = tag_s;
        end
    end

    // Error bookkeeping: a rejection in the same cycle as a clear wins.
    always_comb begin
        error_next_s       = error_r;
        error_count_next_s = error_count_r;
        if (reject_s) begin
            error_next_s = 1'b1;
            if (error_clear) begin
                error_count_next_s = 8'd1;
            end else if (error_count_r == 8'hFF) begin
                error_count_next_s = 8'hFF;
            end else begin
                error_count_next_s = error_count_r + 8'd1;
            end
        end else if (error_clear) begin
            error_next_s       = 1'b0;
            error_count_next_s = 8'd0;
        end else begin
            error_next_s       = error_r;
            error_count_next_s = error_count_r;
        end
    end

    // FIFO storage: pop shifts entry 1 forward; push fills the first free slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            instr0_r <= 32'h0000_0000;
            instr1_r <= 32'h0000_0000;
            addr0_r  <= '0;
            addr1_r  <= '0;
        end else if (pop_s) begin
            if (valid1_r) begin
                // Full: in_ready was low, so no push can coincide here.
                instr0_r <= instr1_r;
                addr0_r  <= addr1_r;
                valid1_r <= 1'b0;
            end else if (push_s) begin
                // One entry popped and replaced: count stays at one.
                instr0_r <= packed_s;
                addr0_r  <= tag_s;
            end else begin
                valid0_r <= 1'b0;
            end
        end else if (push_s) begin
            if (valid0_r) begin
                instr1_r <= packed_s;
                addr1_r  <= tag_s;
                valid1_r <= 1'b1;
            end else begin
                instr0_r <= packed_s;
                addr0_r  <= tag_s;
                valid0_r <= 1'b1;
            end
        end
    end

    // Running emit address.
    always_ff @(posedge clock) begin
        if (reset) begin
            address_r <= '0;
        end else begin
            address_r <= address_next_s;
        end
    end

    // Sticky error flag and saturating reject counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_r       <= 1'b0;
            error_count_r <= 8'd0;
        end else begin
            error_r       <= error_next_s;
            error_count_r <= error_count_next_s;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_encoder
// Directed bench: a table of instruction vectors with hand-computed
// encodings, followed by sequences for backpressure, address load/wrap,
// error clear/saturation and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    opcode_t     in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [7:0]  out_address;
    logic        address_load;
    logic [7:0]  address_load_value;
    logic        error;
    logic [7:0]  error_count;
    logic        error_clear;

    int checks = 0;
    int errors = 0;

    instruction_encoder #(.ADDRESS_WIDTH(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_opcode          (in_opcode),
        .in_rd              (in_rd),
        .in_rs1             (in_rs1),
        .in_rs2             (in_rs2),
        .in_funct3          (in_funct3),
        .in_funct7          (in_funct7),
        .in_immediate       (in_immediate),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_instruction    (out_instruction),
        .out_address        (out_address),
        .address_load       (address_load),
        .address_load_value (address_load_value),
        .error              (error),
        .error_count        (error_count),
        .error_clear        (error_clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        opcode_t     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        rej;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(opcode_t op, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] imm, logic rej, logic [31:0] exp);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.rej = rej; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_opcode    = v.op;
        in_rd        = v.rd;
        in_rs1       = v.rs1;
        in_rs2       = v.rs2;
        in_funct3    = v.f3;
        in_funct7    = v.f7;
        in_immediate = v.imm;
        in_valid     = 1'b1;
    endtask

    logic [7:0]  exp_addr;
    int          exp_err;
    vec_t        va, vb, vc, vbad;

    initial begin
        // opcode, rd, rs1, rs2, f3, f7, imm, reject, expected word
        vecs[0]  = mk(OP_IMM_ARITH, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,           1'b0, 32'h00500093);
        vecs[1]  = mk(OP_STORE,     5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,           1'b0, 32'h0020A423);
        vecs[2]  = mk(OP_BRANCH,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4,         1'b0, 32'hFE000EE3);
        vecs[3]  = mk(OP_LUI,       5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,    1'b0, 32'h123452B7);
        vecs[4]  = mk(OP_JAL,       5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,        1'b0, 32'h001000EF);
        vecs[5]  = mk(OP_IMM_ARITH, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,        1'b1, 32'h0);
        vecs[6]  = mk(OP_BRANCH,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,           1'b1, 32'h0);
        vecs[7]  = mk(OP_REG,       5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF,   1'b0, 32'h002081B3);
        vecs[8]  = mk(OP_REG,       5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,          1'b0, 32'h402081B3);
        vecs[9]  = mk(OP_IMM_ARITH, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, -32'sd2048,     1'b0, 32'h80000093);
        vecs[10] = mk(OP_IMM_ARITH, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,        1'b0, 32'h7FF00093);
        vecs[11] = mk(OP_BRANCH,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,        1'b0, 32'h7E000FE3);
        vecs[12] = mk(OP_BRANCH,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,        1'b1, 32'h0);
        vecs[13] = mk(OP_JAL,       5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576,   1'b0, 32'h8000006F);
        vecs[14] = mk(OP_JAL,       5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,     1'b1, 32'h0);
        vecs[15] = mk(OP_LUI,       5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001,    1'b1, 32'h0);
        vecs[16] = mk(OP_STORE,     5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd2049,      1'b1, 32'h0);
        vecs[17] = mk(OP_AUIPC,     5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000,    1'b0, 32'hFFFFF097);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        address_load = 1'b0; address_load_value = 8'h00; error_clear = 1'b0;
        in_opcode = OP_REG; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_immediate = 32'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_instruction", out_instruction, 32'd0);
        check("rst out_address", {24'd0, out_address}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst error", {31'd0, error}, 32'd0);
        check("rst error_count", {24'd0, error_count}, 32'd0);

        // Table: one vector per two cycles, output checked right after accept
        exp_addr = 8'h00;
        exp_err  = 0;
        for (int i = 0; i < NV; i++) begin
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            drive(vecs[i]);
            tick();
            in_valid = 1'b0;
            if (vecs[i].rej) begin
                exp_err++;
                check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd0);
                check($sformatf("vec%0d error", i), {31'd0, error}, 32'd1);
                check($sformatf("vec%0d error_count", i), {24'd0, error_count}, exp_err);
            end else begin
                check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
                check($sformatf("vec%0d instruction", i), out_instruction, vecs[i].exp);
                check($sformatf("vec%0d address", i), {24'd0, out_address}, {24'd0, exp_addr});
                exp_addr = exp_addr + 8'd4;
            end
            tick();
            check($sformatf("vec%0d drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Clear errors, then a reject coinciding with clear wins
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("clear error", {31'd0, error}, 32'd0);
        check("clear error_count", {24'd0, error_count}, 32'd0);
        vbad = vecs[5];
        drive(vbad);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("reject+clear error", {31'd0, error}, 32'd1);
        check("reject+clear count", {24'd0, error_count}, 32'd1);
        // Saturation: keep rejecting well past 255
        for (int k = 0; k < 260; k++) tick();
        in_valid = 1'b0;
        check("saturated count", {24'd0, error_count}, 32'd255);
        check("reject no output", {31'd0, out_valid}, 32'd0);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("clear after sat", {24'd0, error_count}, 32'd0);

        // Backpressure: three back-to-back inputs with out_ready low
        va = vecs[0]; vb = vecs[1]; vc = vecs[7];
        out_ready = 1'b0;
        drive(va);
        tick();
        check("bp A accepted ready", {31'd0, in_ready}, 32'd1);
        drive(vb);
        tick();
        check("bp full in_ready", {31'd0, in_ready}, 32'd0);
        drive(vc);
        tick();
        check("bp still full", {31'd0, in_ready}, 32'd0);
        check("bp head stable", out_instruction, va.exp);
        check("bp head addr", {24'd0, out_address}, {24'd0, exp_addr});
        out_ready = 1'b1;
        tick();  // pops A; full FIFO refuses C this cycle
        check("bp B at head", out_instruction, vb.exp);
        check("bp B addr", {24'd0, out_address}, {24'd0, exp_addr + 8'd4});
        check("bp ready after pop", {31'd0, in_ready}, 32'd1);
        tick();  // pops B, accepts C
        in_valid = 1'b0;
        check("bp C at head", out_instruction, vc.exp);
        check("bp C addr", {24'd0, out_address}, {24'd0, exp_addr + 8'd8});
        tick();
        check("bp drained", {31'd0, out_valid}, 32'd0);
        exp_addr = exp_addr + 8'd12;

        // Address load with accept, then wrap to 0x00
        drive(va);
        address_load = 1'b1; address_load_value = 8'hFC;
        tick();
        address_load = 1'b0;
        check("load addr", {24'd0, out_address}, 32'h000000FC);
        drive(vb);
        tick();
        in_valid = 1'b0;
        check("wrap addr", {24'd0, out_address}, 32'h00000000);
        check("wrap instr", out_instruction, vb.exp);
        tick();

        // Reset with two entries buffered; reset overrides a pending input
        out_ready = 1'b0;
        drive(va); tick();
        drive(vb); tick();
        check("pre-reset full", {31'd0, in_ready}, 32'd0);
        drive(vc);
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
        check("mid-reset instr", out_instruction, 32'd0);
        check("mid-reset addr", {24'd0, out_address}, 32'd0);
        drive(va);
        tick();
        in_valid = 1'b0;
        check("post-reset addr", {24'd0, out_address}, 32'd0);
        check("post-reset valid", {31'd0, out_valid}, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
